// File: rtl/mem_write_checker.sv
// mem_write_checker: compares snooped data-memory stores against a preloaded table of expected stores
module mem_write_checker #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MODE           = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               exp_wr_en,
   input  logic [ADDR_W-1:0]                  exp_addr,
   input  logic [DATA_W-1:0]                  exp_data,
   input  logic                               start,
   input  logic                               MemWrite,
   input  logic [ADDR_W-1:0]                  DataAdr,
   input  logic [DATA_W-1:0]                  WriteData,
   output logic                               busy,
   output logic                               done,
   output logic                               pass,
   output logic                               fail,
   output logic                               timeout,
   output logic                               overflow,
   output logic [$clog2(DEPTH+1)-1:0]          match_count,
   output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cycle_count,
   output logic [ADDR_W-1:0]                  fail_addr,
   output logic [DATA_W-1:0]                  fail_data
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] tbl_a [DEPTH];
   logic [DATA_W-1:0] tbl_d [DEPTH];
   logic [CW-1:0] count;
   logic [ADDR_W-1:0] cur_a;
   logic [DATA_W-1:0] cur_d;
   logic chk, hit_a, hit, miss, last;
   // compare the store sampled this cycle against the next expected entry and pick the next state
   always_comb begin
      cur_a   = tbl_a[match_count[IW-1:0]];
      cur_d   = tbl_d[match_count[IW-1:0]];
      chk     = state == RUN && MemWrite && match_count != count;
      hit_a   = DataAdr == cur_a;
      hit     = chk && hit_a && WriteData == cur_d;
      miss    = chk && !hit && (MODE == 0 || hit_a);
      last    = hit && match_count + CW'(1) == count;
      state_n = (state == IDLE && start) ? RUN
              : state != RUN ? state
              : (match_count == count || last) ? PASS
              : miss ? FAIL
              : cycle_count == TW'(TIMEOUT_CYCLES-1) ? TOUT
              : RUN;
   end
   // state register with registered status flags decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         fail    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         busy    <= state_n == RUN;
         done    <= state_n == PASS || state_n == FAIL || state_n == TOUT;
         pass    <= state_n == PASS;
         fail    <= state_n == FAIL;
         timeout <= state_n == TOUT;
      end
   end
   // expected-store table loading while idle; loads beyond capacity are dropped and flagged
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_a[i] <= '0;
            tbl_d[i] <= '0;
         end
      end else if (state == IDLE && exp_wr_en) begin
         if (count == CW'(DEPTH)) begin
            overflow <= 1'b1;
         end else begin
            tbl_a[count[IW-1:0]] <= exp_addr;
            tbl_d[count[IW-1:0]] <= exp_data;
            count                <= count + CW'(1);
         end
      end
   end
   // match progress, saturating run-cycle counter and capture of the offending store
   always_ff @(posedge clk) begin
      if (reset) begin
         match_count <= '0;
         cycle_count <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
      end else begin
         if (hit) match_count <= match_count + CW'(1);
         if (state == RUN && cycle_count != TW'(TIMEOUT_CYCLES)) cycle_count <= cycle_count + TW'(1);
         if (miss) begin
            fail_addr <= DataAdr;
            fail_data <= WriteData;
         end
      end
   end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed checks of ordered and address-filtered store checking, timeout and overflow
module tb_mem_write_checker;
   logic clk = 1'b0, reset = 1'b1;
   logic exp_wr_en = 1'b0, start = 1'b0, MemWrite = 1'b0;
   logic [31:0] exp_addr = '0, exp_data = '0, DataAdr = '0, WriteData = '0;
   logic busy0, done0, pass0, fail0, timeout0, overflow0;
   logic busy1, done1, pass1, fail1, timeout1, overflow1;
   logic [3:0] mc0, mc1;
   logic [4:0] cc0, cc1;
   logic [31:0] fa0, fd0, fa1, fd1;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   mem_write_checker #(.DEPTH(8), .TIMEOUT_CYCLES(16), .MODE(0)) u0 (
      .clk(clk), .reset(reset), .exp_wr_en(exp_wr_en), .exp_addr(exp_addr), .exp_data(exp_data),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout(timeout0), .overflow(overflow0),
      .match_count(mc0), .cycle_count(cc0), .fail_addr(fa0), .fail_data(fd0));
   mem_write_checker #(.DEPTH(8), .TIMEOUT_CYCLES(16), .MODE(1)) u1 (
      .clk(clk), .reset(reset), .exp_wr_en(exp_wr_en), .exp_addr(exp_addr), .exp_data(exp_data),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout(timeout1), .overflow(overflow1),
      .match_count(mc1), .cycle_count(cc1), .fail_addr(fa1), .fail_data(fd1));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask
   task automatic load(input logic [31:0] a, input logic [31:0] d);
      exp_wr_en = 1'b1; exp_addr = a; exp_data = d;
      tick();
      exp_wr_en = 1'b0;
   endtask
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      tick();
      MemWrite = 1'b0;
   endtask
   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   initial begin
      tick();
      reset = 1'b0;
      chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_pass", pass0, 0);
      chk("rst_fail", fail0, 0); chk("rst_timeout", timeout0, 0); chk("rst_overflow", overflow0, 0);
      chk("rst_mc", mc0, 0); chk("rst_cc", cc0, 0); chk("rst_fa", fa0, 0); chk("rst_fd", fd0, 0);
      load(96, 7); load(100, 25); go();
      chk("m0_busy", busy0, 1); chk("m0_cc0", cc0, 0);
      store(96, 7);
      chk("m0_mc1", mc0, 1); chk("m0_pass_early", pass0, 0);
      store(100, 25);
      chk("m0_mc2", mc0, 2); chk("m0_pass", pass0, 1); chk("m0_done", done0, 1); chk("m0_busy_off", busy0, 0);
      tick();
      chk("m0_cc_frozen", cc0, 2); chk("m0_pass_sticky", pass0, 1);
      do_reset(); load(96, 7); load(100, 25); go();
      store(104, 25);
      chk("m0_fail", fail0, 1); chk("m0_fa", fa0, 104); chk("m0_fd", fd0, 25); chk("m0_fail_mc", mc0, 0);
      store(96, 7);
      chk("m0_fail_keep", fail0, 1); chk("m0_fail_mc_keep", mc0, 0); chk("m0_fa_keep", fa0, 104); chk("m0_no_pass", pass0, 0);
      do_reset(); load(100, 25); go();
      store(96, 1);
      chk("m0_strict_fail", fail0, 1);
      store(96, 2);
      chk("m1_ignore_busy", busy1, 1); chk("m1_ignore_mc", mc1, 0); chk("m1_ignore_fail", fail1, 0);
      store(100, 25);
      chk("m1_pass", pass1, 1); chk("m1_mc", mc1, 1);
      do_reset(); load(100, 25); go();
      store(96, 1); store(100, 24);
      chk("m1_fail", fail1, 1); chk("m1_fd", fd1, 24); chk("m1_fa", fa1, 100); chk("m1_fail_pass", pass1, 0);
      do_reset(); load(100, 25); go();
      repeat (15) tick();
      chk("to_not_yet", timeout0, 0); chk("to_busy", busy0, 1); chk("to_cc15", cc0, 15);
      tick();
      chk("to_timeout", timeout0, 1); chk("to_done", done0, 1); chk("to_cc_sat", cc0, 16);
      tick();
      chk("to_cc_hold", cc0, 16);
      do_reset(); load(100, 25); go();
      repeat (15) tick();
      store(100, 25);
      chk("to_pass_wins", pass0, 1); chk("to_pass_no_to", timeout0, 0);
      do_reset(); load(100, 25); go();
      repeat (15) tick();
      store(100, 9);
      chk("to_fail_wins", fail0, 1); chk("to_fail_no_to", timeout0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) load(200 + 4 * i, 'h10 + i);
      chk("ov_not_yet", overflow0, 0);
      load(999, 1);
      chk("ov_set", overflow0, 1);
      go();
      for (int i = 0; i < 8; i++) store(200 + 4 * i, 'h10 + i);
      chk("ov_pass", pass0, 1); chk("ov_mc8", mc0, 8); chk("ov_sticky", overflow0, 1);
      do_reset(); go();
      chk("empty_busy", busy0, 1); chk("empty_pass_early", pass0, 0);
      tick();
      chk("empty_pass", pass0, 1); chk("empty_cc", cc0, 1);
      do_reset();
      exp_wr_en = 1'b1; exp_addr = 96; exp_data = 7; start = 1'b1;
      tick();
      exp_wr_en = 1'b0; start = 1'b0;
      chk("ld_start_busy", busy0, 1);
      load(100, 25);
      store(96, 7);
      chk("ld_run_ignored", pass0, 1); chk("ld_run_mc", mc0, 1);
      do_reset(); load(96, 7); load(100, 25); go();
      store(96, 7);
      chk("mid_mc1", mc0, 1);
      do_reset();
      chk("mid_busy", busy0, 0); chk("mid_mc", mc0, 0); chk("mid_cc", cc0, 0); chk("mid_done", done0, 0);
      go();
      chk("mid_busy_again", busy0, 1);
      tick();
      chk("mid_empty_pass", pass0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
